// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode width, opcode values and flag bundle layout.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_NOT = 3'd2;
  localparam logic [OP_W-1:0] ALU_AND = 3'd3;
  localparam logic [OP_W-1:0] ALU_OR  = 3'd4;
  localparam logic [OP_W-1:0] ALU_XOR = 3'd5;
  localparam logic [OP_W-1:0] ALU_SLT = 3'd6;
  localparam logic [OP_W-1:0] ALU_EQ  = 3'd7;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one WIDTH+1 adder shared by ADD, SUB and SLT, plus bitwise and compare ops.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic             sub_mode;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             add_ovf;

  // SLT reuses the subtractor: sign of a-b corrected by its overflow
  assign sub_mode = (op == ALU_SUB) || (op == ALU_SLT);
  assign addend   = sub_mode ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, sub_mode};
  assign add_ovf  = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = add_ovf;
      end
      ALU_SUB: begin
        result   = sum[WIDTH-1:0];
        carry    = ~sum[WIDTH];
        overflow = add_ovf;
      end
      ALU_NOT: result = ~a;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      ALU_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ready/valid ALU pipeline with full backpressure (latency 2, one op per cycle).
// Optional signed saturation of ADD/SUB results is enabled by defining ALU_PIPE_SAT_EN.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

`ifdef ALU_PIPE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic             vld_p1;
  logic             vld_p2;
  logic             adv_p1;
  logic             adv_p2;
  logic [OP_W-1:0]  op_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [WIDTH-1:0] core_res;
  logic             core_c;
  logic             core_v;
  logic [WIDTH-1:0] res_sat;
  logic [WIDTH-1:0] res_p2;
  alu_flags_t       flags_p2;

  // Overflow only ever comes from ADD/SUB, so it alone selects saturation.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                input logic             ovf,
                                                input logic             a_msb);
    return (SAT_EN && ovf) ? {a_msb, {(WIDTH-1){~a_msb}}} : r;
  endfunction

  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = adv_p1;

  // Stage 1: capture operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) begin
      op_p1 <= op;
      a_p1  <= a;
      b_p1  <= b;
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op       (op_p1),
    .a        (a_p1),
    .b        (b_p1),
    .result   (core_res),
    .carry    (core_c),
    .overflow (core_v)
  );

  assign res_sat = saturate(core_res, core_v, a_p1[WIDTH-1]);

  // Stage 2: result and flags; zero/negative follow the saturated value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      res_p2   <= '0;
      flags_p2 <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2   <= res_sat;
        flags_p2 <= {core_c, core_v, (res_sat == '0), res_sat[WIDTH-1]};
      end
    end
  end

  assign out_valid = vld_p2;
  assign result    = res_p2;
  assign carry     = flags_p2.carry;
  assign overflow  = flags_p2.overflow;
  assign zero      = flags_p2.zero;
  assign negative  = flags_p2.negative;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, handshake corner sequences,
// randomized traffic scored against an arithmetic reference model, and a WIDTH=8 instance.
module tb_alu_pipe;
  import alu_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [31:0]     a;
  logic [31:0]     b;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     result;
  logic            carry, overflow, zero, negative;

  logic            in8_valid;
  logic            in8_ready;
  logic [OP_W-1:0] op8;
  logic [7:0]      a8, b8;
  logic            out8_valid;
  logic            out8_ready;
  logic [7:0]      res8;
  logic            c8, v8, z8, n8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in8_valid), .in_ready(in8_ready), .op(op8),
    .a(a8), .b(b8), .out_valid(out8_valid), .out_ready(out8_ready), .result(res8),
    .carry(c8), .overflow(v8), .zero(z8), .negative(n8)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  typedef struct {
    string           name;
    logic [OP_W-1:0] op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     res;
    logic [3:0]      flags;
  } vec_t;

  vec_t vecs[13];
  exp_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values
  function automatic exp_t model(input int w, input logic [OP_W-1:0] f,
                                 input logic [31:0] ai, input logic [31:0] bi);
    exp_t   e;
    longint m, ua, ub, sa, sb, smax, smin, r, s;
    logic   c, v;
    m    = (longint'(1) << w) - 1;
    ua   = longint'(ai) & m;
    ub   = longint'(bi) & m;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -smax - 1;
    sa   = (ua > smax) ? ua - m - 1 : ua;
    sb   = (ub > smax) ? ub - m - 1 : ub;
    c = 1'b0; v = 1'b0; r = 0; s = 0;
    case (f)
      ALU_ADD: begin r = (ua + ub) & m; c = (ua + ub) > m; s = sa + sb; v = (s > smax) || (s < smin); end
      ALU_SUB: begin r = (ua - ub) & m; c = ua < ub;       s = sa - sb; v = (s > smax) || (s < smin); end
      ALU_NOT: r = ~ua & m;
      ALU_AND: r = ua & ub;
      ALU_OR:  r = ua | ub;
      ALU_XOR: r = ua ^ ub;
      ALU_SLT: r = (sa < sb) ? 1 : 0;
      default: r = (ua == ub) ? 1 : 0;
    endcase
`ifdef ALU_PIPE_SAT_EN
    if (v) r = (s > smax) ? smax : (smin & m);
`endif
    e.res = 32'(r);
    e.c   = c;
    e.v   = v;
    e.z   = (r == 0);
    e.n   = ((r >> (w - 1)) & 1) != 0;
    return e;
  endfunction

  // Scoreboard: predict on every accepted beat, compare on every delivered beat
  logic        hold;
  logic [36:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      hold = 1'b0;
    end else begin
      if (hold)
        chk("hold_stable", 32'(held[36:32] ^ {out_valid, carry, overflow, zero, negative}) | (held[31:0] ^ result), 32'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got result 0x%0h expected no output", result);
        end else begin
          e = sb_q.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_flags", {28'd0, carry, overflow, zero, negative}, {28'd0, e.c, e.v, e.z, e.n});
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(32, op, a, b));
      hold = out_valid && !out_ready;
      held = {out_valid, carry, overflow, zero, negative, result};
    end
  end

  task automatic set_vec(input int i, input string nm, input logic [OP_W-1:0] f,
                         input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] r, input logic [3:0] fl);
    vecs[i].name  = nm;
    vecs[i].op    = f;
    vecs[i].a     = va;
    vecs[i].b     = vb;
    vecs[i].res   = r;
    vecs[i].flags = fl;
  endtask

  task automatic apply_vec(input vec_t v);
    int n;
    n = 0;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
    @(negedge clk);
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({v.name, "_valid"}, 32'(out_valid), 32'd1);
    chk({v.name, "_result"}, result, v.res);
    chk({v.name, "_flags"}, {28'd0, carry, overflow, zero, negative}, {28'd0, v.flags});
  endtask

  task automatic run8(input logic [OP_W-1:0] f, input logic [7:0] va, input logic [7:0] vb,
                      output logic [7:0] r, output logic [3:0] fl, output logic vld);
    @(posedge clk); #1;
    out8_ready = 1'b1; in8_valid = 1'b1; op8 = f; a8 = va; b8 = vb;
    @(posedge clk); #1 in8_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    r   = res8;
    fl  = {c8, v8, z8, n8};
    vld = out8_valid;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int   first_acc, first_out, last_out, outs, n;
    exp_t e;
    logic [7:0] r8;
    logic [3:0] f8;
    logic       vld8;

    // {carry, overflow, zero, negative}
`ifdef ALU_PIPE_SAT_EN
    set_vec(0,  "add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF, 4'b0100);
    set_vec(8,  "sub_ovf",  ALU_SUB, 32'h80000000, 32'h1, 32'h80000000, 4'b0101);
`else
    set_vec(0,  "add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0101);
    set_vec(8,  "sub_ovf",  ALU_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0100);
`endif
    set_vec(1,  "sub_eq",   ALU_SUB, 32'd5,        32'd5,        32'h0,        4'b0010);
    set_vec(2,  "sub_brw",  ALU_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b1001);
    set_vec(3,  "slt_neg",  ALU_SLT, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000);
    set_vec(4,  "slt_pos",  ALU_SLT, 32'h1,        32'hFFFFFFFF, 32'h0,        4'b0010);
    set_vec(5,  "eq_true",  ALU_EQ,  32'hDEADBEEF, 32'hDEADBEEF, 32'h1,        4'b0000);
    set_vec(6,  "not_zero", ALU_NOT, 32'h0,        32'h12345678, 32'hFFFFFFFF, 4'b0001);
    set_vec(7,  "add_cry",  ALU_ADD, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1010);
    set_vec(9,  "xor",      ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000);
    set_vec(10, "and",      ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0001);
    set_vec(11, "or",       ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b0001);
    set_vec(12, "slt_ext",  ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h1,        4'b0000);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    in8_valid = 1'b0; out8_ready = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    hold = 1'b0; held = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, carry, overflow, zero, negative}, 32'd0);
    chk("rst_out8_valid", 32'(out8_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Backpressure: two beats fill the pipe, the third must wait
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = ALU_ADD; a = 32'd1; b = 32'd1;
    @(negedge clk); chk("bp_ready1", 32'(in_ready), 32'd1);
    @(posedge clk); #1 a = 32'd2; b = 32'd2;
    @(negedge clk); chk("bp_ready2", 32'(in_ready), 32'd1);
    @(posedge clk); #1 a = 32'd3; b = 32'd3;
    @(negedge clk);
    chk("bp_ready3", 32'(in_ready), 32'd0);
    chk("bp_stall_valid", 32'(out_valid), 32'd1);
    chk("bp_stall_res", result, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_still_stalled", 32'(in_ready), 32'd0);
    chk("bp_held_res", result, 32'd2);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_out1", result, 32'd2);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out2_valid", 32'(out_valid), 32'd1);
    chk("bp_out2", result, 32'd4);
    @(negedge clk);
    chk("bp_out3_valid", 32'(out_valid), 32'd1);
    chk("bp_out3", result, 32'd6);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; op = ALU_ADD; a = 32'd10; b = 32'd20;
    @(posedge clk); #1 a = 32'd30; b = 32'd40;
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_inflight_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_flags", {28'd0, carry, overflow, zero, negative}, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("mid_rst_no_stale", 32'(n), 32'd0);

    // Streaming at full rate
    first_acc = -1; first_out = -1; last_out = -1; outs = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i < 10) begin
        in_valid = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready && first_acc < 0) first_acc = i;
      if (out_valid) begin
        outs++;
        if (first_out < 0) first_out = i;
        last_out = i;
      end
    end
    chk("stream_count", 32'(outs), 32'd10);
    chk("stream_latency", 32'(first_out - first_acc), 32'd2);
    chk("stream_back_to_back", 32'(last_out - first_out), 32'd9);

    // Random traffic with random backpressure, corner operands mixed in
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = 32'h7FFFFFFF;
        1:       a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    // WIDTH=8 instance
    run8(ALU_ADD, 8'hFF, 8'h01, r8, f8, vld8);
    chk("w8_add_valid", 32'(vld8), 32'd1);
    chk("w8_add_result", 32'(r8), 32'h00);
    chk("w8_add_flags", 32'(f8), 32'b1010);
    for (int i = 0; i < 12; i++) begin
      logic [OP_W-1:0] f;
      logic [7:0]      va, vb;
      f  = (i == 0) ? ALU_SUB : 3'($urandom_range(0, 7));
      va = (i == 0) ? 8'h80 : 8'($urandom);
      vb = (i == 0) ? 8'h01 : 8'($urandom);
      e = model(8, f, {24'd0, va}, {24'd0, vb});
      run8(f, va, vb, r8, f8, vld8);
      chk("w8_rand_result", 32'(r8), e.res);
      chk("w8_rand_flags", 32'(f8), {28'd0, e.c, e.v, e.z, e.n});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
